// File: rtl/csa_cpa_86.sv
// Chunked carry-propagate adder that resolves the CSA tree's two output vectors.
// Adds CHUNK bits per cycle with a registered carry between chunks.
module csa_cpa_86 #(
  parameter int WIDTH = 86,
  parameter int CHUNK = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST   = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [CW-1:0]    CLAST = CW'(NCHUNK - 1);
  localparam logic [WIDTH:0]   CBIT  = (WIDTH + 1)'(1) << CHUNK;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'(CBIT - 1'b1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;

  logic [31:0]      off;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK:0]   sum_w;

  // The top chunk may be narrower than CHUNK; the bits above WIDTH
  // shift in as zero, so its carry-out lands at sum_w[LAST].
  always_comb begin
    off   = 32'(cnt_q) * 32'(CHUNK);
    a_sh  = a_q >> off;
    b_sh  = b_q >> off;
    sum_w = {1'b0, a_sh[CHUNK-1:0]}
          + {1'b0, b_sh[CHUNK-1:0]}
          + (CHUNK + 1)'(cy_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          cy_d    = 1'b0;
          state_d = RUN;
        end
      end
      state_q == RUN: begin
        res_d = (res_q & ~(CMASK << off))
              | (WIDTH'(sum_w[CHUNK-1:0]) << off);
        cy_d  = sum_w[CHUNK];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CLAST) begin
          cout_d  = sum_w[LAST];
          state_d = DONE;
        end
      end
      state_q == DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign out_sum   = res_q;
  assign out_cout  = cout_q;

endmodule
